// File: rtl/trial_div_prime.sv
// Deterministic primality tester: odd trial divisors d with d*d <= n, each
// remainder computed by a bit-serial restoring divider (one bit per cycle).
module trial_div_prime #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] start_number,
    input  logic [WIDTH-1:0] accuracy,
    output logic             prime,
    output logic             finish
);

    localparam int DW = WIDTH / 2 + 2;   // divisor and remainder width
    localparam int SW = WIDTH + 2;       // running square width
    localparam int CW = $clog2(WIDTH);   // bit counter width

    typedef enum logic [2:0] {
        CHECK,
        COMPARE,
        DIV,
        REM,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] shreg;
    logic [DW-1:0]    d;
    logic [DW-1:0]    rem;
    logic [SW-1:0]    sq;
    logic [CW-1:0]    bit_cnt;
    logic             prime_next, finish_next;
    logic [DW-1:0]    rem_shift, rem_sub;

    // Only present so the port list matches key_gen's prober.
    logic accuracy_unused;
    assign accuracy_unused = ^accuracy;

    // rem < d always holds, so its top bit is zero and can be shifted out.
    assign rem_shift = {rem[DW-2:0], shreg[WIDTH-1]};
    assign rem_sub   = (rem_shift >= d) ? rem_shift - d : rem_shift;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next  = state;
        prime_next  = prime;
        finish_next = finish;
        case (state)
            CHECK: begin
                if (n < WIDTH'(2)) begin
                    state_next  = DONE;
                    prime_next  = 1'b0;
                    finish_next = 1'b1;
                end else if (n == WIDTH'(2) || n == WIDTH'(3)) begin
                    state_next  = DONE;
                    prime_next  = 1'b1;
                    finish_next = 1'b1;
                end else if (!n[0]) begin
                    state_next  = DONE;
                    prime_next  = 1'b0;
                    finish_next = 1'b1;
                end else begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (sq > SW'(n)) begin
                    state_next  = DONE;
                    prime_next  = 1'b1;
                    finish_next = 1'b1;
                end else begin
                    state_next = DIV;
                end
            end
            DIV: begin
                if (bit_cnt == '0) state_next = REM;
            end
            REM: begin
                if (rem == '0) begin
                    state_next  = DONE;
                    prime_next  = 1'b0;
                    finish_next = 1'b1;
                end else begin
                    state_next = COMPARE;
                end
            end
            default: state_next = DONE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CHECK;
            n       <= start_number;
            d       <= DW'(3);
            sq      <= SW'(9);
            rem     <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            prime   <= 1'b0;
            finish  <= 1'b0;
        end else begin
            state  <= state_next;
            prime  <= prime_next;
            finish <= finish_next;
            case (state)
                COMPARE: begin
                    if (state_next == DIV) begin
                        shreg   <= n;
                        rem     <= '0;
                        bit_cnt <= CW'(WIDTH - 1);
                    end
                end
                DIV: begin
                    rem     <= rem_sub;
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                end
                REM: begin
                    // (d+2)^2 = d^2 + 4d + 4, using the old d.
                    if (rem != '0) begin
                        sq <= sq + (SW'(d) << 2) + SW'(4);
                        d  <= d + DW'(2);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
